// File: rtl/axioma_trace_pkg.sv
// Shared definitions for the PC trace buffer.
// Contents: capture state encodings, trace entry width and the field
// offsets of pc/instr/sreg within an entry, plus an entry packing helper.
package axioma_trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ARMED     = 2'd1,
      ST_TRIGGERED = 2'd2,
      ST_DONE      = 2'd3
   } trace_state_t;

   localparam int TRACE_ENTRY_W = 40;

   // entry layout: {pc[15:0], instr[15:0], sreg[7:0]}
   localparam int TE_SREG_LSB  = 0;
   localparam int TE_SREG_W    = 8;
   localparam int TE_INSTR_LSB = 8;
   localparam int TE_INSTR_W   = 16;
   localparam int TE_PC_LSB    = 24;
   localparam int TE_PC_W      = 16;

   function automatic logic [TRACE_ENTRY_W-1:0] pack_entry(
      input logic [TE_PC_W-1:0]    pc,
      input logic [TE_INSTR_W-1:0] instr,
      input logic [TE_SREG_W-1:0]  sreg
   );
      return {pc, instr, sreg};
   endfunction

endpackage

// File: rtl/axioma_trace_ram.sv
// DEPTH x TRACE_ENTRY_W trace storage: one write port, one synchronous read
// port. Read data is registered and holds its value between reads.
// Ports:
//   clk, reset          system clock, synchronous active-high reset (read reg)
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr           read request; data appears on rd_data next cycle
//   rd_data                 registered read data
module axioma_trace_ram
   import axioma_trace_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [TRACE_ENTRY_W-1:0] wr_data,
   input  logic                     rd_en,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic [TRACE_ENTRY_W-1:0] rd_data
);

   logic [TRACE_ENTRY_W-1:0] mem [DEPTH];
   logic [TRACE_ENTRY_W-1:0] rd_data_d, rd_data_q;

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) rd_data_d = mem[rd_addr];
   end

   // array itself is not reset; only the output register is
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) rd_data_q <= '0;
      else       rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/axioma_pc_trace_buffer.sv
// PC-change trace capture behind axioma_cpu. Records {pc, instr, sreg} on
// every PC change into a circular buffer once armed, stops a programmable
// number of entries after a PC-match trigger, then drains oldest-first.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   debug_pc/instruction/sreg     CPU debug taps
//   arm                           pulse: clear buffer and start recording
//   trig_en, trig_pc              PC-match trigger
//   post_count                    entries recorded after the trigger (latched on arm)
//   filter_seq                    suppress pc == last_pc+1 steps
//   rd_req -> rd_valid/rd_pc/rd_instr/rd_sreg   readout, 1-cycle latency, DONE only
//   state, entries, wrapped, trig_hit          status
//
// state        | meaning
// ST_IDLE      | after reset, nothing recorded, reads ignored
// ST_ARMED     | recording change events, waiting for trigger
// ST_TRIGGERED | recording, counting down post_rem
// ST_DONE      | buffer frozen, readout allowed
module axioma_pc_trace_buffer
   import axioma_trace_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       debug_pc,
   input  logic [15:0]       debug_instruction,
   input  logic [7:0]        debug_sreg,
   input  logic              arm,
   input  logic              trig_en,
   input  logic [15:0]       trig_pc,
   input  logic [ADDR_W:0]   post_count,
   input  logic              filter_seq,
   input  logic              rd_req,
   output logic              rd_valid,
   output logic [15:0]       rd_pc,
   output logic [15:0]       rd_instr,
   output logic [7:0]        rd_sreg,
   output logic [1:0]        state,
   output logic [ADDR_W:0]   entries,
   output logic              wrapped,
   output logic              trig_hit
);

   localparam int              CNT_W     = ADDR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   trace_state_t             state_d, state_q;
   logic [15:0]              last_pc_d, last_pc_q;
   logic [ADDR_W-1:0]        wr_ptr_d, wr_ptr_q;
   logic [ADDR_W-1:0]        rd_ptr_d, rd_ptr_q;
   logic [CNT_W-1:0]         entries_d, entries_q;
   logic [CNT_W-1:0]         post_rem_d, post_rem_q;
   logic                     wrapped_d, wrapped_q;
   logic                     trig_hit_d, trig_hit_q;
   logic                     rd_valid_d, rd_valid_q;

   logic                     change_evt;
   logic [15:0]              pc_inc;
   logic                     wr_en, rd_en;
   logic [TRACE_ENTRY_W-1:0] rd_data;

   always_comb begin
      state_d    = state_q;
      last_pc_d  = debug_pc;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      entries_d  = entries_q;
      post_rem_d = post_rem_q;
      wrapped_d  = wrapped_q;
      trig_hit_d = trig_hit_q;
      rd_valid_d = 1'b0;
      wr_en      = 1'b0;
      rd_en      = 1'b0;

      // 16-bit wrap makes 0xFFFF -> 0x0000 a sequential step
      pc_inc     = last_pc_q + 16'd1;
      change_evt = (debug_pc != last_pc_q) && !(filter_seq && (debug_pc == pc_inc));

      if (arm) begin
         state_d    = ST_ARMED;
         wr_ptr_d   = '0;
         entries_d  = '0;
         wrapped_d  = 1'b0;
         trig_hit_d = 1'b0;
         post_rem_d = post_count;
      end else begin
         case (state_q)
            ST_ARMED, ST_TRIGGERED: begin
               if (change_evt) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  if (entries_q == DEPTH_CNT) wrapped_d = 1'b1;
                  else                        entries_d = entries_q + 1'b1;

                  if (state_q == ST_ARMED) begin
                     if (trig_en && (debug_pc == trig_pc)) begin
                        trig_hit_d = 1'b1;
                        state_d    = (post_rem_q == '0) ? ST_DONE : ST_TRIGGERED;
                     end
                  end else begin
                     post_rem_d = post_rem_q - 1'b1;
                     if (post_rem_q == CNT_W'(1)) state_d = ST_DONE;
                  end

                  // oldest entry; a full buffer gives entries[ADDR_W-1:0]==0 -> wr_ptr
                  if (state_d == ST_DONE) rd_ptr_d = wr_ptr_d - entries_d[ADDR_W-1:0];
               end
            end
            ST_DONE: begin
               if (rd_req && (entries_q != '0)) begin
                  rd_en      = 1'b1;
                  rd_valid_d = 1'b1;
                  rd_ptr_d   = rd_ptr_q + 1'b1;
                  entries_d  = entries_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         last_pc_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         entries_q  <= '0;
         post_rem_q <= '0;
         wrapped_q  <= 1'b0;
         trig_hit_q <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_pc_q  <= last_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         entries_q  <= entries_d;
         post_rem_q <= post_rem_d;
         wrapped_q  <= wrapped_d;
         trig_hit_q <= trig_hit_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   axioma_trace_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q),
      .wr_data (pack_entry(debug_pc, debug_instruction, debug_sreg)),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data)
   );

   assign rd_valid = rd_valid_q;
   assign rd_pc    = rd_data[TE_PC_LSB    +: TE_PC_W];
   assign rd_instr = rd_data[TE_INSTR_LSB +: TE_INSTR_W];
   assign rd_sreg  = rd_data[TE_SREG_LSB  +: TE_SREG_W];
   assign state    = state_q;
   assign entries  = entries_q;
   assign wrapped  = wrapped_q;
   assign trig_hit = trig_hit_q;

endmodule
